// File: rtl/isqrt_rr_arbiter_if.sv
// Bundle between two square-root requesters, the shared isqrt unit and the arbiter.
// Handshake: an operand transfers in any cycle where reqN_vld && reqN_rdy; rdy is a
// same-cycle grant, so x is sampled only then; res/isqrt pulses are valid-only, no backpressure.
interface isqrt_rr_arbiter_if;
  logic        req0_vld;
  logic [31:0] req0_x;
  logic        req0_rdy;
  logic        res0_vld;
  logic [15:0] res0_y;
  logic        req1_vld;
  logic [31:0] req1_x;
  logic        req1_rdy;
  logic        res1_vld;
  logic [15:0] res1_y;
  logic        isqrt_x_vld;
  logic [31:0] isqrt_x;
  logic        isqrt_y_vld;
  logic [15:0] isqrt_y;
  logic        err;

  modport slave (
    input  req0_vld, req0_x, req1_vld, req1_x, isqrt_y_vld, isqrt_y,
    output req0_rdy, res0_vld, res0_y, req1_rdy, res1_vld, res1_y,
           isqrt_x_vld, isqrt_x, err
  );

  modport master (
    output req0_vld, req0_x, req1_vld, req1_x, isqrt_y_vld, isqrt_y,
    input  req0_rdy, res0_vld, res0_y, req1_rdy, res1_vld, res1_y,
           isqrt_x_vld, isqrt_x, err
  );
endinterface

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin sharing of one in-order pipelined isqrt unit between two requesters;
// a tag FIFO of owner IDs steers each returning result back to whoever issued it.
module isqrt_rr_arbiter #(
  parameter int TAG_DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  isqrt_rr_arbiter_if.slave bus
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 last_grant;

  logic                 can_issue;
  logic                 grant0;
  logic                 grant1;
  logic                 push;
  logic                 pop;
  logic                 pop_tag;

  logic                 res0_vld_q;
  logic                 res1_vld_q;
  logic [15:0]          res0_y_q;
  logic [15:0]          res1_y_q;
  logic                 err_q;

  // Full blocks issue even when a pop lands in the same cycle, keeping rdy off the result path.
  always_comb begin
    can_issue = (count < CW'(TAG_DEPTH));
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (can_issue) begin
      if (bus.req0_vld && bus.req1_vld) begin
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (bus.req0_vld) begin
        grant0 = 1'b1;
      end else if (bus.req1_vld) begin
        grant1 = 1'b1;
      end
    end
    push    = grant0 | grant1;
    pop     = bus.isqrt_y_vld && (count != '0);
    pop_tag = tag_mem[rd_ptr];
  end

  assign bus.req0_rdy    = grant0;
  assign bus.req1_rdy    = grant1;
  assign bus.isqrt_x_vld = push;
  assign bus.isqrt_x     = grant1 ? bus.req1_x : bus.req0_x;
  assign bus.res0_vld    = res0_vld_q;
  assign bus.res1_vld    = res1_vld_q;
  assign bus.res0_y      = res0_y_q;
  assign bus.res1_y      = res1_y_q;
  assign bus.err         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      res0_vld_q <= 1'b0;
      res1_vld_q <= 1'b0;
      res0_y_q   <= '0;
      res1_y_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      res0_vld_q <= pop && !pop_tag;
      res1_vld_q <= pop && pop_tag;
      if (pop && !pop_tag) res0_y_q <= bus.isqrt_y;
      if (pop && pop_tag)  res1_y_q <= bus.isqrt_y;

      if (push) begin
        tag_mem[wr_ptr] <= grant1;
        wr_ptr          <= wr_ptr + PW'(1);
        last_grant      <= grant1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // A result with no owner means the isqrt unit and the tag FIFO have diverged.
      if (bus.isqrt_y_vld && (count == '0)) err_q <= 1'b1;
    end
  end
endmodule
